// File: rtl/mem_fill_pkg.sv
// Shared constants and types for the cache-block fill controller.
package mem_fill_pkg;

    localparam int unsigned WORDS_PER_BLK = 8;
    localparam int unsigned DEF_MEM_LAT   = 4;
    localparam int unsigned WORD_IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_META = 2'd2
    } fill_state_e;

endpackage

// File: rtl/fill_word_ctr.sv
// Loadable word-index counter wrapping modulo WORDS; tc flags the last index of a block
// relative to the loaded start value.
module fill_word_ctr
    import mem_fill_pkg::*;
#(
    parameter int unsigned WORDS = WORDS_PER_BLK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_IDX_W-1:0] load_val,
    input  logic                  inc,
    output logic [WORD_IDX_W-1:0] count,
    output logic                  tc
);

    localparam logic [WORD_IDX_W-1:0] TOP = WORD_IDX_W'(WORDS - 1);

    logic [WORD_IDX_W-1:0] last;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            last  <= '0;
        end else if (load) begin
            count <= load_val;
            // The final index of the block is the one just before the start, modulo WORDS.
            last  <= (load_val == '0) ? TOP : load_val - 1'b1;
        end else if (inc) begin
            count <= (count == TOP) ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/mem_fill_ctrl.sv
// Cache-block fill controller: arbitrates I/D misses (D first), streams WORDS memory reads,
// writes returned data then metadata. Optional macro FILL_CRITICAL_WORD_FIRST_EN starts at the missed word.
module mem_fill_ctrl
    import mem_fill_pkg::*;
#(
    parameter int unsigned MEM_LAT = DEF_MEM_LAT,
    parameter int unsigned WORDS   = WORDS_PER_BLK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic        d_miss,
    input  logic [15:0] i_miss_addr,
    input  logic [15:0] d_miss_addr,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic        mem_rd_vld,
    input  logic [15:0] mem_rd_data,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        i_data_we,
    output logic        i_meta_we,
    output logic        d_data_we,
    output logic        d_meta_we,
    output logic        busy,
    output logic        grant_d
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] FILL = ST_FILL;
    localparam logic [1:0] META = ST_META;

    // Returns are tracked by mem_rd_vld, so the latency value only documents the memory.
    localparam int unsigned MEM_LAT_UNUSED = MEM_LAT;

    logic [1:0]            state;
    logic [11:0]           base;
    logic                  own_d;
    logic                  issue_done;
    logic                  req;
    logic                  grant;
    logic                  in_fill;
    logic                  in_meta;
    logic                  ret_vld;
    logic [15:0]           sel_addr;
    logic [WORD_IDX_W-1:0] start_idx;
    logic [WORD_IDX_W-1:0] issue_idx;
    logic [WORD_IDX_W-1:0] ret_idx;
    logic                  issue_tc;
    logic                  ret_tc;
    logic                  addr_lsb_unused;

    assign req      = d_miss | i_miss;
    assign sel_addr = d_miss ? d_miss_addr : i_miss_addr;
    assign grant    = (state == IDLE) && req;
    assign in_fill  = (state == FILL);
    assign in_meta  = (state == META);
    assign ret_vld  = in_fill && mem_rd_vld;
    assign addr_lsb_unused = ^sel_addr[3:0];

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = sel_addr[3:1];
`else
    assign start_idx = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            own_d      <= 1'b0;
            issue_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= FILL;
                        base       <= sel_addr[15:4];
                        own_d      <= d_miss;
                        issue_done <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_en && issue_tc)
                        issue_done <= 1'b1;
                    if (ret_vld && ret_tc)
                        state <= META;
                end
                META:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    fill_word_ctr #(.WORDS(WORDS)) u_issue_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (start_idx),
        .inc      (mem_en),
        .count    (issue_idx),
        .tc       (issue_tc)
    );

    fill_word_ctr #(.WORDS(WORDS)) u_ret_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (start_idx),
        .inc      (ret_vld),
        .count    (ret_idx),
        .tc       (ret_tc)
    );

    assign mem_en    = in_fill && !issue_done;
    assign mem_addr  = mem_en ? {base, issue_idx, 1'b0} : '0;
    assign busy      = in_fill || in_meta;
    assign grant_d   = busy && own_d;

    assign i_data_we = ret_vld && !own_d;
    assign d_data_we = ret_vld && own_d;
    assign i_meta_we = in_meta && !own_d;
    assign d_meta_we = in_meta && own_d;

    assign fill_data = ret_vld ? mem_rd_data : '0;
    assign fill_addr = ret_vld ? {base, ret_idx, 1'b0} :
                       in_meta ? {base, 4'b0000}     : '0;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Self-checking bench for mem_fill_ctrl: fixed-latency memory model plus a timeline reference
// model computed from the grant cycle.
module tb_mem_fill_ctrl;
    import mem_fill_pkg::*;

    localparam int LAT = DEF_MEM_LAT;
    localparam int W   = WORDS_PER_BLK;
    localparam int E   = LAT + W + 1;

    logic        clk = 1'b0;
    logic        rst, i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        mem_en, mem_rd_vld;
    logic [15:0] mem_addr, mem_rd_data, fill_addr, fill_data;
    logic        i_data_we, i_meta_we, d_data_we, d_meta_we, busy, grant_d;

    always #5 clk = ~clk;

    mem_fill_ctrl #(.MEM_LAT(LAT), .WORDS(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_miss      (i_miss),
        .d_miss      (d_miss),
        .i_miss_addr (i_miss_addr),
        .d_miss_addr (d_miss_addr),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rd_vld  (mem_rd_vld),
        .mem_rd_data (mem_rd_data),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data),
        .i_data_we   (i_data_we),
        .i_meta_we   (i_meta_we),
        .d_data_we   (d_data_we),
        .d_meta_we   (d_meta_we),
        .busy        (busy),
        .grant_d     (grant_d)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] salt;
    logic        extra_vld = 1'b0;
    int          rq_due[$];
    logic [15:0] rq_addr[$];

    // reference model: one fill described by its grant cycle, owner, base and start word
    bit          m_act = 1'b0;
    int          m_g   = 0;
    bit          m_d   = 1'b0;
    logic [11:0] m_base = '0;
    int          m_start = 0;

    int          cnt_idwe, cnt_imeta, cnt_ddwe, cnt_dmeta;
    bit          have_first;
    logic [15:0] first_maddr, meta_faddr;
    logic        s_busy, s_grant_d;
    int          s_cyc;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h03b5) ^ salt;
    endfunction

    function automatic logic [2:0] midx(input int j);
        return 3'((m_start + j) % W);
    endfunction

    function automatic bit model_busy();
        return m_act && (cyc - m_g) >= 1 && (cyc - m_g) <= E;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic clear_counts();
        cnt_idwe = 0; cnt_imeta = 0; cnt_ddwe = 0; cnt_dmeta = 0;
        have_first = 1'b0; first_maddr = '0; meta_faddr = '0;
    endtask

    task automatic tick();
        logic [15:0] a, e_maddr, e_faddr, e_fdata;
        logic [6:0]  e_ctrl;
        int          off;
        bit          act, e_en, e_ret, e_meta, drop_d, drop_i;
        if (rq_due.size() > 0 && rq_due[0] == cyc) begin
            mem_rd_vld  = 1'b1;
            mem_rd_data = mem_word(rq_addr[0]);
            void'(rq_due.pop_front());
            void'(rq_addr.pop_front());
        end else begin
            mem_rd_vld  = extra_vld;
            mem_rd_data = extra_vld ? 16'($urandom) : '0;
        end
        @(negedge clk);
        if (!rst && !model_busy() && (d_miss || i_miss)) begin
            a       = d_miss ? d_miss_addr : i_miss_addr;
            m_act   = 1'b1;
            m_g     = cyc;
            m_d     = d_miss;
            m_base  = a[15:4];
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            m_start = int'(a[3:1]);
`else
            m_start = 0;
`endif
        end
        off     = cyc - m_g;
        act     = m_act && off >= 1 && off <= E;
        e_en    = act && off <= W;
        e_ret   = act && off >= LAT + 1 && off <= LAT + W;
        e_meta  = act && off == E;
        e_maddr = e_en ? {m_base, midx(off - 1), 1'b0} : '0;
        e_faddr = e_ret ? {m_base, midx(off - LAT - 1), 1'b0} :
                  e_meta ? {m_base, 4'b0000} : '0;
        e_fdata = e_ret ? mem_word(e_faddr) : '0;
        e_ctrl  = {e_en, act, act && m_d, e_ret && !m_d, e_meta && !m_d, e_ret && m_d, e_meta && m_d};
        check("ctrl", {25'd0, mem_en, busy, grant_d, i_data_we, i_meta_we, d_data_we, d_meta_we}, {25'd0, e_ctrl});
        check("mem_addr", {16'd0, mem_addr}, {16'd0, e_maddr});
        check("fill_addr", {16'd0, fill_addr}, {16'd0, e_faddr});
        check("fill_data", {16'd0, fill_data}, {16'd0, e_fdata});
        if (i_data_we === 1'b1) cnt_idwe++;
        if (i_meta_we === 1'b1) cnt_imeta++;
        if (d_data_we === 1'b1) cnt_ddwe++;
        if (d_meta_we === 1'b1) cnt_dmeta++;
        if (i_meta_we === 1'b1 || d_meta_we === 1'b1) meta_faddr = fill_addr;
        if (mem_en === 1'b1) begin
            if (!have_first) begin
                have_first  = 1'b1;
                first_maddr = mem_addr;
            end
            rq_due.push_back(cyc + LAT);
            rq_addr.push_back(mem_addr);
        end
        s_busy    = busy;
        s_grant_d = grant_d;
        s_cyc     = cyc;
        if (rst) m_act = 1'b0;
        drop_d = e_meta && m_d;
        drop_i = e_meta && !m_d;
        @(posedge clk);
        #1;
        cyc++;
        // the cache retires its miss once its metadata has been written
        if (drop_d) d_miss = 1'b0;
        if (drop_i) i_miss = 1'b0;
    endtask

    initial begin
        int req_c, fall;
        bit seen_busy;
        logic [15:0] exp_first;
        salt        = 16'($urandom);
        rst         = 1'b1;
        i_miss      = 1'b0;
        d_miss      = 1'b0;
        i_miss_addr = '0;
        d_miss_addr = '0;
        mem_rd_vld  = 1'b0;
        mem_rd_data = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", {31'd0, s_busy}, 32'd0);

        // D miss at 0x1234: address sequence, pulse counts, meta address, latency
        clear_counts();
        d_miss = 1'b1; d_miss_addr = 16'h1234;
        req_c = cyc;
        tick();
        fall = -1; seen_busy = 1'b0;
        for (int n = 0; n < 40 && fall < 0; n++) begin
            tick();
            if (s_busy === 1'b1) seen_busy = 1'b1;
            else if (seen_busy) fall = s_cyc;
        end
        check("d_latency", 32'(fall - req_c), 32'(1 + LAT + W + 1));
        check("d_data_pulses", 32'(cnt_ddwe), 32'(W));
        check("d_meta_pulses", 32'(cnt_dmeta), 32'd1);
        check("d_meta_addr", {16'd0, meta_faddr}, 32'h1230);
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        exp_first = 16'h1234;
`else
        exp_first = 16'h1230;
`endif
        check("d_first_addr", {16'd0, first_maddr}, {16'd0, exp_first});
        check("no_i_we", 32'(cnt_idwe + cnt_imeta), 32'd0);

        // simultaneous I and D misses: D served first, I granted right after D's meta
        clear_counts();
        d_miss = 1'b1; d_miss_addr = 16'($urandom);
        i_miss = 1'b1; i_miss_addr = 16'($urandom);
        tick();
        tick();
        check("both_grant_d", {31'd0, s_grant_d}, 32'd1);
        repeat (E - 1) tick();
        check("both_i_during_d", 32'(cnt_idwe + cnt_imeta), 32'd0);
        check("both_d_data", 32'(cnt_ddwe), 32'(W));
        for (int n = 0; n < 40 && (i_miss || d_miss || model_busy()); n++) tick();
        check("both_i_data", 32'(cnt_idwe), 32'(W));
        check("both_i_meta", 32'(cnt_imeta), 32'd1);

        // I miss at 0x00A6: start word depends on the critical-word-first build
        clear_counts();
        i_miss = 1'b1; i_miss_addr = 16'h00A6;
        for (int n = 0; n < 40 && (i_miss || model_busy()); n++) tick();
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        exp_first = 16'h00A6;
`else
        exp_first = 16'h00A0;
`endif
        check("cwf_first_addr", {16'd0, first_maddr}, {16'd0, exp_first});
        check("cwf_i_data", 32'(cnt_idwe), 32'(W));

        // reset in the cycle of the 3rd return aborts the fill; stale returns are ignored
        clear_counts();
        d_miss = 1'b1; d_miss_addr = 16'($urandom);
        tick();
        repeat (LAT + 2) tick();
        rst = 1'b1; d_miss = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_writes_before", 32'(cnt_ddwe), 32'd3);
        clear_counts();
        tick();
        check("abort_idle", {31'd0, s_busy}, 32'd0);
        repeat (12) tick();
        check("abort_no_writes", 32'(cnt_ddwe + cnt_dmeta + cnt_idwe + cnt_imeta), 32'd0);

        // I miss dropped after 2 FILL cycles still completes
        clear_counts();
        i_miss = 1'b1; i_miss_addr = 16'($urandom);
        tick();
        repeat (2) tick();
        i_miss = 1'b0;
        repeat (E) tick();
        check("drop_i_data", 32'(cnt_idwe), 32'(W));
        check("drop_i_meta", 32'(cnt_imeta), 32'd1);

        // spurious returns while idle
        clear_counts();
        extra_vld = 1'b1;
        repeat (4) tick();
        extra_vld = 1'b0;
        check("idle_vld_writes", 32'(cnt_ddwe + cnt_dmeta + cnt_idwe + cnt_imeta), 32'd0);

        // randomized miss patterns with idle gaps (occasionally with spurious returns)
        for (int it = 0; it < 25; it++) begin
            int sel;
            sel = $urandom_range(0, 2);
            if (sel != 1) begin d_miss = 1'b1; d_miss_addr = 16'($urandom); end
            if (sel != 0) begin i_miss = 1'b1; i_miss_addr = 16'($urandom); end
            for (int n = 0; n < 60 && (i_miss || d_miss || model_busy()); n++) tick();
            extra_vld = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 4)) tick();
            extra_vld = 1'b0;
        end
        check("rand_drained", {30'd0, i_miss, d_miss}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have parameter MEM_LAT, default 4: cycles from mem_en to mem_rd_vld.
REQ-003 SHALL have parameter WORDS, default 8: 16-bit words per cache block.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-006 SHALL have ports i_miss / d_miss, input, 1 each: miss flags from the I-cache / D-cache.
REQ-007 SHALL have ports i_miss_addr / d_miss_addr, input, 16 each: CPU address of the miss.
REQ-008 SHALL have ports mem_en (output, 1), mem_addr (output, 16): pipelined memory read request, one per cycle.
REQ-009 SHALL have ports mem_rd_vld (input, 1), mem_rd_data (input, 16): in-order memory read return.
REQ-010 SHALL have ports fill_addr (output, 16), fill_data (output, 16): cache write address and data.
REQ-011 SHALL have ports i_data_we, i_meta_we, d_data_we, d_meta_we, output, 1 each: per-cache write enables.
REQ-012 SHALL have ports busy (output, 1) and grant_d (output, 1): fill in progress; owner is the D-cache.

Function
REQ-013 SHALL implement states IDLE, FILL and META.
REQ-014 In IDLE, SHALL grant d_miss over i_miss (fixed priority) and latch the winner's address bits [15:4] as block base; on grant, SHALL go to FILL.
REQ-015 In FILL, SHALL assert mem_en for exactly WORDS consecutive cycles, starting the cycle after grant, with mem_addr = {base, issue_idx, 1'b0}.
REQ-016 On each mem_rd_vld in FILL, SHALL drive fill_data = mem_rd_data and fill_addr = {base, ret_idx, 1'b0}, and assert the granted cache's data_we in the same cycle (combinational, zero latency).
REQ-017 After the WORDS-th return, SHALL go to META, assert the granted cache's meta_we for exactly 1 cycle with fill_addr = {base, 4'b0}, then return to IDLE.
REQ-018 Once granted, a fill SHALL complete even if the miss drops, and a fill is never preempted.
REQ-019 A miss still asserted in the first IDLE cycle after META SHALL be treated as a new request; the cache metadata is updated at the META edge, so the served miss is already low.
REQ-020 In IDLE and META, SHALL ignore mem_rd_vld.
REQ-021 busy SHALL be high in FILL and META.
REQ-022 grant_d SHALL be valid while busy.
REQ-023 Minimum miss-to-IDLE latency SHALL be 1 + MEM_LAT + WORDS + 1 cycles (14 at defaults).
REQ-024 issue_idx and ret_idx SHALL be 3-bit counters that wrap modulo WORDS.

Reset
REQ-025 When rst is high at a clock edge, SHALL go to IDLE, clear counters and base, and drive all outputs to 0.
REQ-026 A reset mid-FILL SHALL abort the fill without a meta write, and later stale returns SHALL be ignored.

Configuration
REQ-027 With FILL_CRITICAL_WORD_FIRST_EN defined, issue_idx and ret_idx SHALL start at the miss address bits [3:1] and wrap modulo WORDS.
REQ-028 Without FILL_CRITICAL_WORD_FIRST_EN, issue_idx and ret_idx SHALL start at 0.

Structure
REQ-029 Package mem_fill_pkg SHALL hold the state enum, WORDS_PER_BLK = 8, DEF_MEM_LAT = 4 and the word-index width (3).
REQ-030 SHALL contain one sub-module, fill_word_ctr: a loadable wrapping 3-bit counter with a terminal-count flag, instantiated twice (issue and return).

Verification
REQ-031 d_miss=1, d_miss_addr=0x1234, default build -> mem_addr 0x1230..0x123E over 8 cycles; 8 d_data_we pulses; one d_meta_we with fill_addr=0x1230; busy falls 14 cycles after the request.
REQ-032 i_miss and d_miss rise in the same cycle -> D block filled first (grant_d=1); I fill begins in the IDLE cycle after D's META, with no i_*_we during the D fill.
REQ-033 FILL_CRITICAL_WORD_FIRST_EN defined, i_miss_addr=0x00A6 -> mem_addr order 0x00A6, 0x00A8, ..., 0x00AE, 0x00A0, 0x00A2, 0x00A4; fill_addr follows the same order.
REQ-034 rst pulsed after the 3rd return -> IDLE the next cycle; no meta_we; returns 4-8 produce no data_we; outputs are 0.
REQ-035 i_miss dropped after 2 cycles of FILL -> all 8 i_data_we pulses and the i_meta_we still occur.
REQ-036 mem_rd_vld asserted while IDLE -> no write enables asserted.
